muldiv32: RTL and testbench
===========================

# muldiv32

Iterative 32-bit multiply/divide unit in the execute stage, between the register-file/decode stage and the HI/LO registers. Accepts the two register operands and a 2-bit operation code for mult, multu, div and divu. Computes the 64-bit result over 32 iterations with a start/busy/done handshake. Presents the result as the HI/LO pair, with `done` acting as the HI/LO write enable.

## Interface
Parameters:
- none (fixed 32-bit datapath, fixed 32-iteration latency)

Ports:
- clock  in  1  single system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  launch request; sampled only in IDLE
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu (funct[1:0] of 011000..011011)
- operand_a  in  32  rs value (multiplicand / dividend)
- operand_b  in  32  rt value (multiplier / divisor)
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse; hi_result/lo_result are valid and new in this cycle
- hi_result  out  32  mult: product[63:32]; div: remainder
- lo_result  out  32  mult: product[31:0]; div: quotient
- div_by_zero  out  1  asserted together with done when a div/divu had a zero divisor; held until the next done

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches op, operand_a and operand_b, records the sign flags, loads the absolute values (signed ops) or raw values (unsigned ops), sets count=31, and goes to RUN.
  - start=0 in IDLE: stay in IDLE.
  - RUN: one iteration per cycle; count decrements; on count==0, write the results and go to DONE.
  - DONE: done=1; unconditionally go to IDLE next edge.
- start is ignored in RUN and DONE; no queuing.
- Inputs after the accepting edge have no effect; latched copies are used.
- Multiply: radix-2 shift-add on unsigned magnitudes, with a 64-bit accumulator.
  - Signed op with differing operand signs: two's-complement negate the 64-bit product.
- Divide: restoring division on unsigned magnitudes, with a 32-bit remainder and a 32-bit quotient shift register.
  - Signed div: quotient is negated if the signs differ; remainder takes the sign of the dividend (truncating division).
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000; no error flag.
- Divisor zero (div or divu): run the full 32 cycles anyway; at completion hi=latched operand_a, lo=0xFFFFFFFF, div_by_zero=1.
- hi_result, lo_result and div_by_zero are registered. They change only on the edge entering DONE and hold afterwards.

## Timing
- Reset values:
  - state=IDLE
  - busy=0, done=0
  - hi_result=0, lo_result=0
  - div_by_zero=0
  - count=0
- Reset takes effect asynchronously, including mid-RUN; the partial result is discarded.
- Accepting edge T0: busy=1 from T0 through the cycle before T32.
- Edge T32: busy=0, done=1, and results are valid for the cycle following T32.
- Edge T33: done=0 and state=IDLE; the earliest next accept is at T33 if start=1.
- Latency is fixed at 32 cycles from accept to done for all ops and all operands, with no early termination.
- Issue interval is 33 cycles minimum.
- busy and done are never high in the same cycle.

## Test plan
- mult: op=00, a=0xFFFFFFFF, b=0x00000002, start pulsed at edge T0.
  - Required: busy high for 32 cycles; done at T32 for exactly one cycle; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu: op=01 with the same operands.
  - Required: hi=0x00000001, lo=0xFFFFFFFE.
- div / divu with small operands:
  - op=10, a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - op=11, a=7, b=2 -> lo=3, hi=1.
- div overflow: op=10, a=0x80000000, b=0xFFFFFFFF.
  - Required: lo=0x80000000, hi=0, div_by_zero=0.
- divu by zero: op=11, a=5, b=0.
  - Required: done at T32 with hi=5, lo=0xFFFFFFFF, div_by_zero=1.
  - A following multu 3×4 then gives hi=0, lo=12, div_by_zero=0.
- Handshake and reset robustness:
  - start re-pulsed and operands changed at T5 -> ignored; result matches the original operands.
  - reset asserted mid-cycle during iteration 10 -> busy, done, hi and lo go to 0 without waiting for a clock edge.
  - After reset release, a new multu 3×4 completes normally 32 cycles after its accept.

Source files
------------

// File: rtl/muldiv32_if.sv
// Operand/result bundle between the decode stage, the multiply/divide unit and HI/LO.
interface muldiv32_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi_result;
    logic [31:0] lo_result;
    logic        div_by_zero;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, hi_result, lo_result, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, hi_result, lo_result, div_by_zero
    );
endinterface

// File: rtl/muldiv32.sv
// Iterative 32-bit multiply/divide unit: mult, multu, div, divu in a fixed 32 cycles.
// Signed operations run on magnitudes; the signs are applied when the result is written.
module muldiv32 (
    input  logic      clock,
    input  logic      reset,
    muldiv32_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [4:0]  count;
    logic        is_div;
    logic        neg_main;     // negate product / quotient
    logic        neg_rem;      // remainder follows dividend sign
    logic [31:0] a_raw;        // latched operand_a, returned as HI on divide by zero
    logic [31:0] b_mag;        // multiplicand / divisor magnitude
    logic [63:0] acc;          // mult: {partial high, multiplier}; div: {remainder, quotient}

    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        dbz_q;

    logic        sign_a_in;
    logic        sign_b_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] acc_next;
    logic [63:0] prod_signed;
    logic [31:0] quo_signed;
    logic [31:0] rem_signed;

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi_result   = hi_q;
    assign bus.lo_result   = lo_q;
    assign bus.div_by_zero = dbz_q;

    // Operand sign capture and magnitude conversion for the accept cycle
    always_comb begin
        sign_a_in = ~bus.op[0] & bus.operand_a[31];
        sign_b_in = ~bus.op[0] & bus.operand_b[31];
        a_mag_in  = sign_a_in ? (~bus.operand_a + 32'd1) : bus.operand_a;
        b_mag_in  = sign_b_in ? (~bus.operand_b + 32'd1) : bus.operand_b;
    end

    // One shift-add or restoring-divide step, plus sign fix-up of the final step
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, b_mag};
        if (is_div) begin
            // bit 32 of the difference is the borrow: set means the divisor did not fit
            if (!div_diff[32]) begin
                acc_next = {div_diff[31:0], acc[30:0], 1'b1};
            end else begin
                acc_next = {div_shift[31:0], acc[30:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[31:1]};
        end
        prod_signed = neg_main ? (~acc_next + 64'd1) : acc_next;
        quo_signed  = neg_main ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
        rem_signed  = neg_rem ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
    end

    // Control FSM, iteration datapath and registered HI/LO outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            a_raw    <= '0;
            b_mag    <= '0;
            acc      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div   <= bus.op[1];
                        neg_main <= sign_a_in ^ sign_b_in;
                        neg_rem  <= sign_a_in;
                        a_raw    <= bus.operand_a;
                        b_mag    <= b_mag_in;
                        acc      <= {32'd0, a_mag_in};
                        count    <= 5'd31;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count - 5'd1;
                    if (count == 5'd0) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                        if (!is_div) begin
                            hi_q  <= prod_signed[63:32];
                            lo_q  <= prod_signed[31:0];
                            dbz_q <= 1'b0;
                        end else if (b_mag == 32'd0) begin
                            hi_q  <= a_raw;
                            lo_q  <= '1;
                            dbz_q <= 1'b1;
                        end else begin
                            hi_q  <= rem_signed;
                            lo_q  <= quo_signed;
                            dbz_q <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv32.sv
// Scoreboard bench for muldiv32: the driver pushes hand-computed HI/LO/flag triples,
// the monitor pops and compares them whenever done is presented.
module tb_muldiv32;

    logic clock;
    logic reset;

    muldiv32_if bus ();

    muldiv32 dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: consume one expected entry per done pulse
    always @(negedge clock) begin : monitor
        exp_t e;
        if (bus.done === 1'b1) begin
            check("busy_with_done", {31'd0, bus.busy}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done got=done required=no_done at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("hi_result", bus.hi_result, e.hi);
                check("lo_result", bus.lo_result, e.lo);
                check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
            end
        end
    end

    // Issue one operation and check the 32-cycle busy window and single-cycle done
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed,
                          input bit repulse);
        @(negedge clock);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clock);
        sb.push_back('{hi: eh, lo: el, dbz: ed});
        #1;
        bus.start     = 1'b0;
        bus.op        = ~op;
        bus.operand_a = ~a;
        bus.operand_b = b + 32'd3;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            check("busy_window", {31'd0, bus.busy}, 32'd1);
            check("done_early", {31'd0, bus.done}, 32'd0);
            if (repulse && i == 4) begin
                bus.start     = 1'b1;
                bus.op        = 2'b00;
                bus.operand_a = 32'hDEAD_BEEF;
                bus.operand_b = 32'd1;
            end
            if (repulse && i == 5) bus.start = 1'b0;
        end
        @(negedge clock);
        check("busy_end", {31'd0, bus.busy}, 32'd0);
        check("done_at_t32", {31'd0, bus.done}, 32'd1);
        @(negedge clock);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_hi", bus.hi_result, 32'd0);
        check("rst_lo", bus.lo_result, 32'd0);
        check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        reset = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
        repeat (2) @(negedge clock);
        check("dbz_held", {31'd0, bus.div_by_zero}, 32'd1);
        check("hi_held", bus.hi_result, 32'd5);
        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);

        // Reset in the middle of an iteration: outputs clear without a clock edge
        @(negedge clock);
        bus.start     = 1'b1;
        bus.op        = 2'b01;
        bus.operand_a = 32'h11;
        bus.operand_b = 32'h22;
        @(posedge clock);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("async_rst_done", {31'd0, bus.done}, 32'd0);
        check("async_rst_hi", bus.hi_result, 32'd0);
        check("async_rst_lo", bus.lo_result, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("no_done_after_rst", {31'd0, bus.done}, 32'd0);

        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
